// File: rtl/game_pkg.sv
// Shared constants for the note-matrix display path: matrix geometry,
// row assignments for the game state rows, and the scan state encoding.
package game_pkg;

    localparam int NOTE_COLS = 12;
    localparam int DISP_ROWS = 4;

    localparam int ROW_CURR = 0;
    localparam int ROW_NEXT = 1;
    localparam int ROW_HOLD = 2;
    localparam int ROW_STAT = 3;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } disp_state_t;

endpackage

// File: rtl/led_matrix_driver_frame_buffer.sv
// Double-buffered image store: a producer fills the shadow copy through a
// valid/ready handshake and the scanner promotes it to active at a frame wrap.
module frame_buffer
    import game_pkg::*;
#(
    parameter int ROWS = DISP_ROWS,
    parameter int COLS = NOTE_COLS
)(
    input  logic                   CLOCK_50,
    input  logic                   reset_n,
    input  logic [ROWS*COLS-1:0]   frame_data,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic                   swap,
    output logic [ROWS*COLS-1:0]   active,
    output logic [ROWS*COLS-1:0]   active_next
);

    logic [ROWS*COLS-1:0] shadow;
    logic                 shadow_full;
    logic                 accept;

    assign load_ready = ~shadow_full;
    assign accept     = load_valid && ~shadow_full;

    // A load can only land while the shadow is empty and a swap only acts
    // while it is full, so the two never fight over shadow_full.
    assign active_next = (swap && shadow_full) ? shadow : active;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            shadow      <= '0;
            active      <= '0;
            shadow_full <= 1'b0;
        end else if (accept) begin
            shadow      <= frame_data;
            shadow_full <= 1'b1;
        end else if (swap && shadow_full) begin
            active      <= shadow;
            shadow_full <= 1'b0;
        end
    end

endmodule

// File: rtl/led_matrix_driver.sv
// Multiplexed LED matrix scanner: blanks, then drives one row at a time with
// PWM-dimmed column data taken from a tear-free double-buffered image.
module led_matrix_driver
    import game_pkg::*;
#(
    parameter int ROWS        = DISP_ROWS,
    parameter int COLS        = NOTE_COLS,
    parameter int ROW_TICKS   = 50000,
    parameter int BLANK_TICKS = 500
)(
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic [ROWS*COLS-1:0] frame_data,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [3:0]           brightness,
    output logic [ROWS-1:0]      row_drv,
    output logic [COLS-1:0]      col_drv,
    output logic                 frame_start
);

    localparam int TICK_MAX  = (ROW_TICKS > BLANK_TICKS) ? ROW_TICKS : BLANK_TICKS;
    localparam int TW        = $clog2(TICK_MAX + 1);
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SLICE_LEN = ROW_TICKS / 16;
    localparam int SW        = (SLICE_LEN > 1) ? $clog2(SLICE_LEN) : 1;

    localparam logic [TW-1:0] ROW_LAST   = TW'(ROW_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam logic [SW-1:0] SUB_LAST   = SW'(SLICE_LEN - 1);
    localparam logic [RW-1:0] ROW_MAX    = RW'(ROWS - 1);

    localparam logic [0:0] ST_BLANK = BLANK;
    localparam logic [0:0] ST_DRIVE = DRIVE;

    logic [0:0]           state, state_n;
    logic [TW-1:0]        tick, tick_n;
    logic [RW-1:0]        row, row_inc, next_row;
    logic [3:0]           slice, slice_n;
    logic [SW-1:0]        sub, sub_n;
    logic                 blank_done, drive_done, enter_drive, swap;
    logic [ROWS*COLS-1:0] active, active_next;
    logic [ROWS-1:0]      row_drv_n;
    logic [COLS-1:0]      col_drv_n;
    logic                 frame_start_n;

    frame_buffer #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_frame_buffer (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .frame_data  (frame_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .swap        (swap),
        .active      (active),
        .active_next (active_next)
    );

    assign blank_done  = (state == ST_BLANK) && (tick == BLANK_LAST);
    assign drive_done  = (state == ST_DRIVE) && (tick == ROW_LAST);
    assign row_inc     = (row == ROW_MAX) ? '0 : row + RW'(1);
    assign next_row    = drive_done ? row_inc : row;
    assign swap        = drive_done && (row == ROW_MAX);
    assign enter_drive = blank_done || (drive_done && (BLANK_TICKS == 0));

    // Next-state logic; the PWM slice runs off its own sub-counter so the
    // slice number never needs a divide by ROW_TICKS/16.
    always_comb begin
        state_n = state;
        tick_n  = tick + TW'(1);
        slice_n = slice;
        sub_n   = sub;
        if (enter_drive) begin
            state_n = ST_DRIVE;
            tick_n  = '0;
            slice_n = '0;
            sub_n   = '0;
        end else if (drive_done) begin
            state_n = ST_BLANK;
            tick_n  = '0;
        end else if (state == ST_DRIVE) begin
            if (sub == SUB_LAST) begin
                sub_n   = '0;
                slice_n = slice + 4'd1;
            end else begin
                sub_n = sub + SW'(1);
            end
        end
    end

    // Pin values are computed for the cycle being entered, so the outputs
    // are plain registers; active_next lets a wrap straight into row 0 see the new image.
    always_comb begin
        row_drv_n     = '0;
        col_drv_n     = '0;
        frame_start_n = enter_drive && (next_row == '0);
        if (state_n == ST_DRIVE) begin
            row_drv_n = ROWS'(1) << next_row;
            if (slice_n < brightness) begin
                col_drv_n = active_next[int'(next_row)*COLS +: COLS];
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_BLANK;
            tick        <= '0;
            row         <= '0;
            slice       <= '0;
            sub         <= '0;
            row_drv     <= '0;
            col_drv     <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            tick        <= tick_n;
            row         <= next_row;
            slice       <= slice_n;
            sub         <= sub_n;
            row_drv     <= row_drv_n;
            col_drv     <= col_drv_n;
            frame_start <= frame_start_n;
        end
    end

endmodule

// File: tb/tb_led_matrix_driver.sv
// Directed bench for led_matrix_driver with 16-tick rows and 2-tick blanking,
// so one frame is 4 * 18 = 72 cycles.
module tb_led_matrix_driver;

    localparam int ROWS = 4;
    localparam int COLS = 12;
    localparam int FRAME = 72;

    logic                 CLOCK_50 = 1'b0;
    logic                 reset_n;
    logic [ROWS*COLS-1:0] frame_data;
    logic                 load_valid;
    logic                 load_ready;
    logic [3:0]           brightness;
    logic [ROWS-1:0]      row_drv;
    logic [COLS-1:0]      col_drv;
    logic                 frame_start;

    int checks = 0;
    int errors = 0;

    logic [COLS-1:0] col_or  [ROWS];
    logic [15:0]     on_mask [ROWS];
    int              drv_cnt [ROWS];
    int              leak_cnt;
    int              bad_row_cnt;

    logic [ROWS*COLS-1:0] img1 = {12'h000, 12'h000, 12'h002, 12'h801};
    logic [ROWS*COLS-1:0] img2 = {12'h555, 12'hF00, 12'h0F0, 12'h00F};
    logic [ROWS*COLS-1:0] img3 = {12'h333, 12'h222, 12'h111, 12'hAAA};
    logic [ROWS*COLS-1:0] img4 = {12'hABC, 12'h789, 12'h456, 12'h123};
    logic [ROWS*COLS-1:0] img5 = {12'h924, 12'h3C0, 12'h0C3, 12'hFFF};

    led_matrix_driver #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .ROW_TICKS   (16),
        .BLANK_TICKS (2)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .frame_data  (frame_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .brightness  (brightness),
        .row_drv     (row_drv),
        .col_drv     (col_drv),
        .frame_start (frame_start)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLOCK_50);
        end
    endtask

    task automatic wait_row(input logic [ROWS-1:0] pat, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (row_drv === pat) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLOCK_50);
        end
    endtask

    // Records one whole frame starting at the (next) frame_start cycle.
    task automatic capture_frame(output bit ok);
        int r;
        wait_frame(ok);
        for (int k = 0; k < ROWS; k++) begin
            col_or[k] = '0;
            on_mask[k] = '0;
            drv_cnt[k] = 0;
        end
        leak_cnt = 0;
        bad_row_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            r = -1;
            for (int k = 0; k < ROWS; k++)
                if (row_drv === (4'b0001 << k)) r = k;
            if (row_drv === 4'b0000) begin
                if (col_drv !== '0) leak_cnt++;
            end else if (r < 0) begin
                bad_row_cnt++;
            end else begin
                if (col_drv !== '0) begin
                    if (drv_cnt[r] < 16) on_mask[r][drv_cnt[r]] = 1'b1;
                    col_or[r] = col_or[r] | col_drv;
                end
                drv_cnt[r]++;
            end
            @(negedge CLOCK_50);
        end
    endtask

    task automatic load_frame(input logic [ROWS*COLS-1:0] img, output int waited);
        frame_data = img;
        load_valid = 1'b1;
        waited = 0;
        while (load_ready !== 1'b1 && waited < 500) begin
            @(negedge CLOCK_50);
            waited++;
        end
        @(negedge CLOCK_50);
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checks++; if (row_drv !== 4'b0000) begin errors++; $display("FAIL reset_row_drv got %b want 0000", row_drv); end
        checks++; if (col_drv !== 12'h000) begin errors++; $display("FAIL reset_col_drv got %h want 000", col_drv); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b want 1", load_ready); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        checks++; if (row_drv !== 4'b0000) begin errors++; $display("FAIL blank1_row_drv got %b want 0000", row_drv); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL blank1_frame_start got %b want 0", frame_start); end
        @(negedge CLOCK_50);
        checks++; if (row_drv !== 4'b0001) begin errors++; $display("FAIL first_row_drv got %b want 0001", row_drv); end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL first_frame_start got %b want 1", frame_start); end
        checks++; if (col_drv !== 12'h000) begin errors++; $display("FAIL first_col_drv got %h want 000", col_drv); end
        @(negedge CLOCK_50);
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL frame_start_width got %b want 0", frame_start); end
    endtask

    task automatic test_load_display();
        int waited;
        bit ok;
        load_frame(img1, waited);
        checks++; if (waited !== 0) begin errors++; $display("FAIL load1_wait got %0d want 0", waited); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load1_ready_low got %b want 0", load_ready); end
        capture_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL load1_frame_timeout got 0 want 1"); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (col_or[r] !== img1[r*COLS +: COLS]) begin errors++; $display("FAIL load1_row%0d_cols got %h want %h", r, col_or[r], img1[r*COLS +: COLS]); end
            checks++; if (drv_cnt[r] !== 16) begin errors++; $display("FAIL load1_row%0d_drive got %0d want 16", r, drv_cnt[r]); end
            checks++; if (on_mask[r] !== ((img1[r*COLS +: COLS] != 0) ? 16'h7FFF : 16'h0000)) begin errors++; $display("FAIL load1_row%0d_pwm got %h want %h", r, on_mask[r], ((img1[r*COLS +: COLS] != 0) ? 16'h7FFF : 16'h0000)); end
        end
        checks++; if (leak_cnt !== 0 || bad_row_cnt !== 0) begin errors++; $display("FAIL load1_blank_leak got %0d/%0d want 0/0", leak_cnt, bad_row_cnt); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load1_ready_after_swap got %b want 1", load_ready); end
    endtask

    task automatic test_back_to_back();
        int waited2, waited3;
        bit ok4, ok5;
        load_frame(img2, waited2);
        checks++; if (waited2 !== 0) begin errors++; $display("FAIL b2b_first_wait got %0d want 0", waited2); end
        fork
            load_frame(img3, waited3);
            capture_frame(ok4);
        join
        // Second load is held off until ready rises the cycle after the wrap swap.
        checks++; if (waited3 !== 69) begin errors++; $display("FAIL b2b_second_wait got %0d want 69", waited3); end
        checks++; if (!ok4) begin errors++; $display("FAIL b2b_frame_a_timeout got 0 want 1"); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (col_or[r] !== img2[r*COLS +: COLS]) begin errors++; $display("FAIL b2b_a_row%0d_cols got %h want %h", r, col_or[r], img2[r*COLS +: COLS]); end
        end
        checks++; if (leak_cnt !== 0 || bad_row_cnt !== 0) begin errors++; $display("FAIL b2b_a_blank_leak got %0d/%0d want 0/0", leak_cnt, bad_row_cnt); end
        capture_frame(ok5);
        checks++; if (!ok5) begin errors++; $display("FAIL b2b_frame_b_timeout got 0 want 1"); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (col_or[r] !== img3[r*COLS +: COLS]) begin errors++; $display("FAIL b2b_b_row%0d_cols got %h want %h", r, col_or[r], img3[r*COLS +: COLS]); end
        end
    endtask

    task automatic test_brightness();
        bit ok;
        brightness = 4'd4;
        @(negedge CLOCK_50);
        capture_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bright4_timeout got 0 want 1"); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (on_mask[r] !== 16'h000F) begin errors++; $display("FAIL bright4_row%0d_pwm got %h want 000f", r, on_mask[r]); end
            checks++; if (col_or[r] !== img3[r*COLS +: COLS]) begin errors++; $display("FAIL bright4_row%0d_cols got %h want %h", r, col_or[r], img3[r*COLS +: COLS]); end
        end
        brightness = 4'd0;
        @(negedge CLOCK_50);
        capture_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bright0_timeout got 0 want 1"); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (on_mask[r] !== 16'h0000) begin errors++; $display("FAIL bright0_row%0d_pwm got %h want 0000", r, on_mask[r]); end
            checks++; if (drv_cnt[r] !== 16) begin errors++; $display("FAIL bright0_row%0d_drive got %0d want 16", r, drv_cnt[r]); end
        end
        brightness = 4'd15;
        @(negedge CLOCK_50);
    endtask

    task automatic test_swap_cycle();
        int waited;
        bit ok;
        wait_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL swap_align_timeout got 0 want 1"); end
        load_frame(img4, waited);
        checks++; if (waited !== 0) begin errors++; $display("FAIL swap_preload_wait got %0d want 0", waited); end
        wait_row(4'b1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL swap_row3_timeout got 0 want 1"); end
        repeat (15) @(negedge CLOCK_50);
        checks++; if (row_drv !== 4'b1000) begin errors++; $display("FAIL swap_last_tick_row got %b want 1000", row_drv); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL swap_cycle_ready got %b want 0", load_ready); end
        frame_data = img5;
        load_valid = 1'b1;
        @(negedge CLOCK_50);
        checks++; if (row_drv !== 4'b0000) begin errors++; $display("FAIL swap_blank_row got %b want 0000", row_drv); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL swap_ready_rise got %b want 1", load_ready); end
        @(negedge CLOCK_50);
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL swap_accept_next got %b want 0", load_ready); end
        @(negedge CLOCK_50);
        capture_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL swap_frame_a_timeout got 0 want 1"); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (col_or[r] !== img4[r*COLS +: COLS]) begin errors++; $display("FAIL swap_a_row%0d_cols got %h want %h", r, col_or[r], img4[r*COLS +: COLS]); end
        end
        capture_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL swap_frame_b_timeout got 0 want 1"); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (col_or[r] !== img5[r*COLS +: COLS]) begin errors++; $display("FAIL swap_b_row%0d_cols got %h want %h", r, col_or[r], img5[r*COLS +: COLS]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_row(4'b0100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midreset_row2_timeout got 0 want 1"); end
        repeat (5) @(negedge CLOCK_50);
        checks++; if (col_drv === 12'h000) begin errors++; $display("FAIL midreset_pre_cols got %h want nonzero", col_drv); end
        reset_n = 1'b0;
        #1;
        checks++; if (row_drv !== 4'b0000) begin errors++; $display("FAIL midreset_row_drv got %b want 0000", row_drv); end
        checks++; if (col_drv !== 12'h000) begin errors++; $display("FAIL midreset_col_drv got %h want 000", col_drv); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b want 1", load_ready); end
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        @(negedge CLOCK_50);
        checks++; if (row_drv !== 4'b0000) begin errors++; $display("FAIL midreset_blank_row got %b want 0000", row_drv); end
        @(negedge CLOCK_50);
        checks++; if (row_drv !== 4'b0001 || frame_start !== 1'b1) begin errors++; $display("FAIL midreset_restart got %b/%b want 0001/1", row_drv, frame_start); end
        capture_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL midreset_frame_timeout got 0 want 1"); end
        for (int r = 0; r < ROWS; r++) begin
            checks++; if (col_or[r] !== 12'h000) begin errors++; $display("FAIL midreset_row%0d_cols got %h want 000", r, col_or[r]); end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        frame_data = '0;
        load_valid = 1'b0;
        brightness = 4'd15;
        test_reset();
        test_load_display();
        test_back_to_back();
        test_brightness();
        test_swap_cycle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_matrix_driver.md
Name: led_matrix_driver

Overview:
- Transmit-side counterpart of the keypad matrix scanner: the scanner drives rows and samples columns; this block drives rows and columns to emit a multiplexed LED matrix image.
- Shows the game state on a 4x12 note matrix:
  - row0 = current note
  - row1 = next note
  - row2 = hold-length bar
  - row3 = status/flash
- Sits between the engine/scorer outputs and the GPIO_0 pins.
- Frames are loaded through a valid/ready handshake into a shadow buffer and swapped tear-free at frame boundaries.

Parameters:
- ROWS, 4, number of matrix rows (one-hot row drive).
- COLS, 12, columns per row (one per piano key).
- ROW_TICKS, 50000, CLOCK_50 cycles each row is driven (1 ms); must be a multiple of 16.
- BLANK_TICKS, 500, all-off cycles inserted before each row (anti-ghosting).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- frame_data  in  ROWS*COLS  image; bits [r*COLS +: COLS] = row r, bit c = column c.
- load_valid  in  1  frame_data is valid this cycle.
- load_ready  out  1  shadow buffer empty; a transfer occurs when valid&&ready.
- brightness  in  4  PWM level, 0 = dark, 15 = 15/16 duty.
- row_drv  out  ROWS  one-hot active-high row enable.
- col_drv  out  COLS  active-high column data.
- frame_start  out  1  1-cycle pulse when row 0 begins DRIVE.

Behaviour:
- Reset values (asynchronous, on reset_n low):
  - row_drv=0, col_drv=0, frame_start=0, load_ready=1.
  - active and shadow buffers = 0, shadow_full=0, row index=0.
  - State=BLANK, tick counter=0.
- FSM has two states:
  - BLANK: row_drv=0, col_drv=0 for BLANK_TICKS cycles, then go to DRIVE.
  - DRIVE: row_drv=1<<row, held for ROW_TICKS cycles. Then go to BLANK with row=row+1; wrap from ROWS-1 to 0.
- Registered outputs: row_drv and col_drv change on the clock edge that enters the state, so there is no combinational path from inputs to pins.
- PWM within DRIVE:
  - slice = tick / (ROW_TICKS/16), range 0..15.
  - col_drv = active[row] when slice < brightness, else 0.
  - brightness is sampled every cycle; a change takes effect on the next tick.
- frame_start: asserted for exactly the first cycle of DRIVE with row=0.
- Handshake:
  - load_ready = ~shadow_full.
  - On valid&&ready: shadow <= frame_data, shadow_full <= 1.
  - frame_data is ignored when ready=0; the producer must hold valid.
- Buffer swap:
  - Occurs on the last cycle of DRIVE for row ROWS-1, i.e. the frame wrap.
  - If shadow_full, then active <= shadow and shadow_full <= 0.
  - The next frame displays the new image; no frame ever mixes two images.
- Simultaneous load and swap in the same cycle:
  - The swap uses the old shadow.
  - The load is refused, because ready reflects shadow_full before the swap.
  - ready rises the following cycle.
- Latency: an accepted frame reaches the pins at the start of the next frame. Worst case is 2 frame periods, ROWS*(ROW_TICKS+BLANK_TICKS) cycles each.
- BLANK_TICKS=0 is legal: BLANK is skipped, and DRIVE of the next row follows immediately.
- reset_n asserted mid-row: outputs go to 0 immediately (asynchronously); after release, scanning restarts with BLANK of row 0.
- Counter widths:
  - Tick counter is $clog2(max(ROW_TICKS,BLANK_TICKS)+1) bits.
  - Row index is $clog2(ROWS) bits; must handle ROWS=1.

Decomposition:
- Shared package (game_pkg):
  - NOTE_COLS=12, DISP_ROWS=4.
  - Row index constants ROW_CURR, ROW_NEXT, ROW_HOLD, ROW_STAT.
  - Display state enum {BLANK, DRIVE}.
- One sub-module, frame_buffer: shadow/active registers, valid/ready logic and swap input.
- Scan FSM, tick counter and PWM stay in led_matrix_driver.

Test Plan:
- Bench parameters: ROW_TICKS=16, BLANK_TICKS=2, brightness=15.
1. Reset: hold reset_n=0 -> row_drv=0, col_drv=0, load_ready=1. Release -> 2 blank cycles, then row_drv=0001 with frame_start pulsed once.
2. Load frame with row0=0x801, row1=0x002 at valid&&ready -> load_ready=0 next cycle. Image appears only after the next frame_start: col_drv=0x801 during row0 DRIVE and 0x002 during row1 DRIVE. Then load_ready=1.
3. Second load while shadow_full, valid held -> not accepted until after the swap. Displayed frame is never a mix of the two images.
4. Brightness=4 -> within each 16-cycle DRIVE, col_drv is active exactly 4 cycles (slices 0-3) and 0 for the other 12. Brightness=0 -> col_drv is always 0 while row_drv still cycles.
5. Assert valid on the exact swap cycle -> refused that cycle, accepted the next cycle, shown one frame later.
6. Assert reset_n low mid-row2 DRIVE -> outputs go to 0 immediately. After release, scanning restarts at row0 after BLANK and the active image reads back as 0.
